// File: rtl/ram_request_sequencer_pkg.sv
// Shared types and constants for the RAM request sequencer.
package RAM_SEQ_PKG;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RDATA,
        HOLD
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned CNT_W           = 8;
    localparam logic [7:0]  DOUT_IDLE       = 8'hFF;

endpackage

// File: rtl/ram_seq_edge_detect.sv
// Registers an active-low strobe and flags its falling edge for one cycle.
module ram_seq_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic strobe_n,
    output logic fall_c
);

    logic sync_q;
    logic prev_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= strobe_n;
            prev_q <= sync_q;
        end
    end

    assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/ram_request_sequencer.sv
// Turns level-style host RAM strobes into single req/ack memory transactions.
// Optional one-entry read cache enabled by defining RAM_SEQ_READ_CACHE_EN.
module ram_request_sequencer
    import RAM_SEQ_PKG::*;
#(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
    input  logic                  HOST_OE_n,
    input  logic                  HOST_WE_n,
    input  logic [7:0]            HOST_DIN,
    input  logic                  HOST_RFSH_n,
    output logic [7:0]            HOST_DOUT,
    output logic                  HOST_WAIT_n,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [7:0]            MEM_WDATA,
    input  logic                  MEM_ACK,
    input  logic [7:0]            MEM_RDATA,
    input  logic                  MEM_RVALID,
    output logic                  MEM_RFSH,
    output logic                  ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    req_nxt, we_nxt, err_nxt, rfsh_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [7:0]              wdata_nxt, dout_nxt;
    logic                    rfsh_pend, pend_nxt;
    logic                    oe_fall_c, we_fall_c, rfsh_fall_c;
    logic                    start_c, hit_c, busy_c, expired_c;

    ram_seq_edge_detect u_oe_edge   (.CLK(CLK), .RESET(RESET), .strobe_n(HOST_OE_n),   .fall_c(oe_fall_c));
    ram_seq_edge_detect u_we_edge   (.CLK(CLK), .RESET(RESET), .strobe_n(HOST_WE_n),   .fall_c(we_fall_c));
    ram_seq_edge_detect u_rfsh_edge (.CLK(CLK), .RESET(RESET), .strobe_n(HOST_RFSH_n), .fall_c(rfsh_fall_c));

    assign start_c   = (state == IDLE) && (oe_fall_c || we_fall_c);
    assign busy_c    = (state == REQ) || (state == RDATA);
    assign expired_c = busy_c && (cnt >= CNT_LAST);

`ifdef RAM_SEQ_READ_CACHE_EN
    logic                  cache_valid;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [7:0]            cache_data;
    logic                  fill_c, clear_c;

    assign hit_c = cache_valid && !we_fall_c && (cache_addr == HOST_ADDR);

    // Single-entry cache of the last completed read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= DOUT_IDLE;
        end else if (clear_c) begin
            cache_valid <= 1'b0;
        end else if (fill_c) begin
            cache_valid <= 1'b1;
            cache_addr  <= MEM_ADDR;
            cache_data  <= MEM_RDATA;
        end
    end
`else
    assign hit_c = 1'b0;
`endif

    // Next state and next values of all registered outputs.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        req_nxt     = 1'b0;
        we_nxt      = MEM_WE;
        addr_nxt    = MEM_ADDR;
        wdata_nxt   = MEM_WDATA;
        dout_nxt    = HOST_DOUT;
        err_nxt     = ERR;
        rfsh_nxt    = 1'b0;
        pend_nxt    = rfsh_pend | rfsh_fall_c;
        HOST_WAIT_n = 1'b1;
`ifdef RAM_SEQ_READ_CACHE_EN
        fill_c      = 1'b0;
        clear_c     = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_c && hit_c) begin
`ifdef RAM_SEQ_READ_CACHE_EN
                    dout_nxt = cache_data;
`endif
                    state_nxt = HOLD;
                end else if (start_c) begin
                    HOST_WAIT_n = 1'b0;
                    state_nxt   = REQ;
                    req_nxt     = 1'b1;
                    we_nxt      = we_fall_c;
                    addr_nxt    = HOST_ADDR;
                    wdata_nxt   = HOST_DIN;
`ifdef RAM_SEQ_READ_CACHE_EN
                    clear_c     = we_fall_c;
`endif
                end else if (rfsh_pend) begin
                    // A refresh edge arriving in the firing cycle merges into this pulse.
                    rfsh_nxt = 1'b1;
                    pend_nxt = 1'b0;
                end
            end
            REQ: begin
                HOST_WAIT_n = 1'b0;
                cnt_nxt     = cnt + 1'b1;
                req_nxt     = 1'b1;
                if (MEM_ACK) begin
                    req_nxt = 1'b0;
                    if (MEM_WE) begin
                        state_nxt = HOLD;
                    end else if (MEM_RVALID) begin
                        state_nxt = HOLD;
                        dout_nxt  = MEM_RDATA;
`ifdef RAM_SEQ_READ_CACHE_EN
                        fill_c    = 1'b1;
`endif
                    end else begin
                        state_nxt = RDATA;
                    end
                end else if (expired_c) begin
                    req_nxt   = 1'b0;
                    state_nxt = HOLD;
                    err_nxt   = 1'b1;
                    if (!MEM_WE) dout_nxt = DOUT_IDLE;
`ifdef RAM_SEQ_READ_CACHE_EN
                    clear_c   = 1'b1;
`endif
                end
            end
            RDATA: begin
                HOST_WAIT_n = 1'b0;
                cnt_nxt     = cnt + 1'b1;
                if (MEM_RVALID) begin
                    state_nxt = HOLD;
                    dout_nxt  = MEM_RDATA;
`ifdef RAM_SEQ_READ_CACHE_EN
                    fill_c    = 1'b1;
`endif
                end else if (expired_c) begin
                    state_nxt = HOLD;
                    err_nxt   = 1'b1;
                    dout_nxt  = DOUT_IDLE;
`ifdef RAM_SEQ_READ_CACHE_EN
                    clear_c   = 1'b1;
`endif
                end
            end
            HOLD: begin
                if (HOST_OE_n && HOST_WE_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_RFSH  <= 1'b0;
            HOST_DOUT <= DOUT_IDLE;
            ERR       <= 1'b0;
            rfsh_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            MEM_REQ   <= req_nxt;
            MEM_WE    <= we_nxt;
            MEM_ADDR  <= addr_nxt;
            MEM_WDATA <= wdata_nxt;
            MEM_RFSH  <= rfsh_nxt;
            HOST_DOUT <= dout_nxt;
            ERR       <= err_nxt;
            rfsh_pend <= pend_nxt;
        end
    end

endmodule

// File: doc/ram_request_sequencer.md
# ram_request_sequencer

Converts the level-style RAM requests produced by the cartridge-side ROM/SRAM controllers (address, OE_n/WE_n strobes held for the whole MSX bus cycle) into single req/ack transactions towards the shared memory controller. Sits directly downstream of the PAC ROM controller, between its RAM host port and the memory arbiter. Returns read data to the controller and drives WAIT_n back to it while a transaction is outstanding.

## Interface
- ADDR_WIDTH, 22, byte address width on both sides
- TIMEOUT, 255, cycles allowed between MEM_REQ and completion before abort (1..255)
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- HOST_ADDR  in  ADDR_WIDTH  request address, valid while a strobe is low
- HOST_OE_n  in  1  read strobe, active low
- HOST_WE_n  in  1  write strobe, active low
- HOST_DIN  in  8  write data
- HOST_RFSH_n  in  1  bus refresh indicator, active low
- HOST_DOUT  out  8  read data, held until next completed read
- HOST_WAIT_n  out  1  low while a host access is outstanding
- MEM_REQ  out  1  transaction request, held until MEM_ACK
- MEM_WE  out  1  1 = write, 0 = read; stable while MEM_REQ
- MEM_ADDR  out  ADDR_WIDTH  latched address
- MEM_WDATA  out  8  latched write data
- MEM_ACK  in  1  one-cycle accept of MEM_REQ
- MEM_RDATA  in  8  read data
- MEM_RVALID  in  1  one-cycle read data valid, at or after MEM_ACK
- MEM_RFSH  out  1  one-cycle refresh request pulse
- ERR  out  1  sticky timeout flag, cleared only by RESET

## Operation
- Strobes registered once; access starts on falling edge of OE_n or WE_n (registered value high, current low). WE_n wins if both fall in the same cycle.
- States: IDLE, REQ, RDATA, HOLD.
- IDLE: on start, latch HOST_ADDR/HOST_DIN into MEM_ADDR/MEM_WDATA, set MEM_WE, go REQ.
- REQ: MEM_REQ=1 until MEM_ACK. Write: ACK -> HOLD. Read: ACK -> RDATA, or HOLD directly if MEM_RVALID in the same cycle as ACK (data captured).
- RDATA: on MEM_RVALID capture MEM_RDATA into HOST_DOUT, -> HOLD.
- HOLD: wait until both strobes high, -> IDLE. A new falling edge while in HOLD is impossible by construction (strobe must rise first).
- Timeout: 8-bit counter cleared on leaving IDLE, increments each cycle in REQ/RDATA; reaching TIMEOUT -> HOLD, MEM_REQ dropped, HOST_DOUT=8'hFF for reads, ERR=1.
- Refresh: falling edge of HOST_RFSH_n sets a pending bit; MEM_RFSH pulses for one cycle when state is IDLE and no start in that cycle; pending cleared on pulse. Second edge while pending is merged.
- Strobe rising mid-transaction (REQ/RDATA): transaction still completes; HOLD exits immediately after.

## Timing
- Reset values: MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_RFSH=0, HOST_DOUT=8'hFF, HOST_WAIT_n=1, ERR=0, state IDLE, pending refresh 0.
- Strobe low at cycle N (input) -> edge detected N+1 -> MEM_REQ=1 at N+2.
- HOST_WAIT_n is combinational: 0 when a start is detected in IDLE or state is REQ/RDATA; 1 otherwise. Drops in the detection cycle, rises the cycle after completion.
- HOST_DOUT updates the cycle after MEM_RVALID.
- Zero-wait memory (ACK and RVALID together at N+2): HOST_DOUT valid at N+3.
- RESET mid-transaction: everything returns to reset values next cycle; MEM_REQ dropped without waiting for ACK.

## Configuration
- RAM_SEQ_READ_CACHE_EN defined: one-entry cache (address + data + valid). A read start whose address equals the cached address with valid=1 goes IDLE -> HOLD, HOST_DOUT loaded from cache the next cycle, no MEM_REQ, HOST_WAIT_n stays 1. Any write start or timeout clears valid; completed reads refill it.
- Undefined: every read issues MEM_REQ; no cache storage.

## Structure
- Package RAM_SEQ_PKG: state enum (IDLE, REQ, RDATA, HOLD), TIMEOUT default constant, DOUT_IDLE = 8'hFF.
- One sub-module, ram_seq_edge_detect: registers a strobe, outputs one-cycle fall pulse; instantiated for OE_n, WE_n, RFSH_n.

## Test plan
- Read 0x004000, memory ACK+RVALID same cycle with 0x5A -> MEM_REQ at N+2, HOST_DOUT=0x5A at N+3, WAIT_n low N+1..N+2.
- Write 0x55 to 0x006001, ACK after 5 cycles -> MEM_WE=1, MEM_WDATA=0x55 stable until ACK, WAIT_n low 6 cycles.
- Read, never ACK, TIMEOUT=16 -> MEM_REQ drops after 16 cycles, HOST_DOUT=0xFF, ERR=1 until RESET.
- RFSH_n falls during read transaction -> MEM_RFSH single pulse only after return to IDLE.
- RESET asserted in REQ -> next cycle MEM_REQ=0, HOST_WAIT_n=1, HOST_DOUT=0xFF.
- With RAM_SEQ_READ_CACHE_EN: two reads of 0x004000 (0x77) -> one MEM_REQ, second returns 0x77; intervening write forces a new MEM_REQ.
